// File: rtl/motoro_nphase_drv.sv
// N-phase motor drive: commutation stepping with speed ramp, high-side PWM,
// per-leg dead-time insertion and braking.
module motoro_nphase_leg #(
  parameter int DEAD_CYC = 10
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [1:0] lvl,
  input  logic       pwm_on,
  output logic       hp,
  output logic       lp
);
  localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [1:0] LV_HIGH = 2'd1;
  localparam logic [1:0] LV_LOW  = 2'd2;

  logic [1:0]    lvl_q;
  logic [DW-1:0] dead_q, dead_d;

  // Blanking starts on the cycle the new level is first seen, so gates
  // stay low for exactly DEAD_CYC cycles after every level change.
  always_comb begin
    dead_d = '0;
    if (lvl != lvl_q)       dead_d = DW'(DEAD_CYC);
    else if (dead_q != '0)  dead_d = dead_q - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      lvl_q  <= '0;
      dead_q <= '0;
      hp     <= 1'b0;
      lp     <= 1'b0;
    end else begin
      lvl_q  <= lvl;
      dead_q <= dead_d;
      hp     <= (lvl == LV_HIGH) && pwm_on && (dead_d == '0);
      lp     <= (lvl == LV_LOW) && (dead_d == '0);
    end
  end
endmodule

module motoro_nphase_drv #(
  parameter int PHASES     = 3,
  parameter int CNT_W      = 25,
  parameter int STEP_START = 20000,
  parameter int STEP_MIN   = 100,
  parameter int STEP_DEF   = 2000,
  parameter int STEP_DELTA = 50,
  parameter int DEAD_CYC   = 10,
  parameter int PWM_W      = 8,
  localparam int KW        = $clog2(2 * PHASES)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              m3start,
  input  logic              m3forceStop,
  input  logic              m3invRotate,
  input  logic              m3freqINC,
  input  logic              m3freqDEC,
  input  logic [PWM_W-1:0]  duty,
  output logic [PHASES-1:0] hp,
  output logic [PHASES-1:0] lp,
  output logic              busy,
  output logic [KW-1:0]     stepIdx,
  output logic [CNT_W-1:0]  stepPeriod
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_UP    = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_BRAKE = 3'd4;

  localparam logic [CNT_W-1:0] P_START = CNT_W'(STEP_START);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(STEP_MIN);
  localparam logic [CNT_W-1:0] P_DEF   = CNT_W'(STEP_DEF);
  localparam logic [CNT_W-1:0] P_DELTA = CNT_W'(STEP_DELTA);
  localparam logic [KW-1:0]    K_MAX   = KW'(2 * PHASES - 1);
  localparam logic [KW:0]      K_MOD   = (KW+1)'(2 * PHASES);
  localparam logic [1:0] LV_OFF  = 2'd0;
  localparam logic [1:0] LV_HIGH = 2'd1;
  localparam logic [1:0] LV_LOW  = 2'd2;

  logic [2:0]       state, st_nx;
  logic             dir;
  logic [KW-1:0]    k, k_nx;
  logic [CNT_W-1:0] cnt, cur, cur_nx, tgt, tgt_nx, goal;
  logic [PWM_W-1:0] carrier, duty_r;
  logic             moving, commute, pwm_on;

  assign stepIdx    = k;
  assign stepPeriod = cur;
  assign pwm_on     = carrier < duty_r;
  assign moving     = (state == S_UP) || (state == S_RUN) || (state == S_DOWN);
  assign commute    = moving && (cnt == cur - CNT_W'(1));
  assign goal       = (state == S_DOWN) ? P_START : tgt;
  assign k_nx       = dir ? ((k == '0) ? K_MAX : k - KW'(1))
                          : ((k == K_MAX) ? '0 : k + KW'(1));

  // One STEP_DELTA toward the goal, landing exactly on it when closer.
  always_comb begin
    cur_nx = cur;
    if (cur > goal)      cur_nx = (cur - goal <= P_DELTA) ? goal : cur - P_DELTA;
    else if (cur < goal) cur_nx = (goal - cur <= P_DELTA) ? goal : cur + P_DELTA;
  end

  always_comb begin
    tgt_nx = tgt;
    if (m3freqINC && !m3freqDEC)
      tgt_nx = ({1'b0, tgt} < {1'b0, P_MIN} + {1'b0, P_DELTA}) ? P_MIN : tgt - P_DELTA;
    else if (m3freqDEC && !m3freqINC)
      tgt_nx = ({1'b0, tgt} + {1'b0, P_DELTA} > {1'b0, P_START}) ? P_START : tgt + P_DELTA;
  end

  always_comb begin
    st_nx = state;
    if (m3forceStop) st_nx = S_BRAKE;
    else begin
      case (state)
        S_IDLE:  if (m3start) st_nx = S_UP;
        S_UP:    if (!m3start) st_nx = S_DOWN;
                 else if (commute && cur_nx == tgt) st_nx = S_RUN;
        S_RUN:   if (!m3start) st_nx = S_DOWN;
        S_DOWN:  if (m3start) st_nx = S_UP;
                 else if (commute && cur_nx == P_START) st_nx = S_IDLE;
        default: st_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      dir     <= 1'b0;
      k       <= '0;
      cnt     <= '0;
      cur     <= P_START;
      tgt     <= P_DEF;
      carrier <= '0;
      duty_r  <= '0;
    end else begin
      state   <= st_nx;
      busy    <= st_nx != S_IDLE;
      tgt     <= tgt_nx;
      carrier <= carrier + PWM_W'(1);
      if (carrier == '1) duty_r <= duty;
      // Braking freezes the stepper; a fresh start reinitialises it.
      if (state == S_IDLE && st_nx == S_UP) begin
        k   <= '0;
        cnt <= '0;
        cur <= P_START;
        dir <= m3invRotate;
      end else if (moving && !m3forceStop) begin
        if (commute) begin
          k   <= k_nx;
          cnt <= '0;
          cur <= cur_nx;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  for (genvar p = 0; p < PHASES; p++) begin : g_leg
    localparam logic [KW:0] OFS = (KW+1)'(2 * PHASES - 2 * p);
    logic [KW:0] rel_raw, rel;
    logic [1:0]  lvl;
    // rel = (k - 2p) mod 2*PHASES; the first half of the cycle is HIGH.
    assign rel_raw = {1'b0, k} + OFS;
    assign rel     = (rel_raw >= K_MOD) ? rel_raw - K_MOD : rel_raw;
    assign lvl     = (state == S_IDLE) ? LV_OFF :
                     ((state == S_BRAKE) || (rel >= (KW+1)'(PHASES))) ? LV_LOW : LV_HIGH;

    motoro_nphase_leg #(.DEAD_CYC(DEAD_CYC)) u_leg (
      .clk    (clk),
      .nRst   (nRst),
      .lvl    (lvl),
      .pwm_on (pwm_on),
      .hp     (hp[p]),
      .lp     (lp[p])
    );
  end
endmodule

// File: tb/tb_motoro_nphase_drv.sv
// Bench for motoro_nphase_drv: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model.
module tb_motoro_nphase_drv;
  localparam int P = 3, K2 = 6, SS = 20, SMIN = 4, SDEF = 8, SD = 4, DC = 2;
  localparam int PW = 4, CW = 8, CMAX = 15;

  logic          clk, nRst, m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC;
  logic [PW-1:0] duty;
  logic [P-1:0]  hp, lp;
  logic          busy;
  logic [2:0]    stepIdx;
  logic [CW-1:0] stepPeriod;
  int n_cmp = 0, n_bad = 0;

  motoro_nphase_drv #(
    .PHASES(P), .CNT_W(CW), .STEP_START(SS), .STEP_MIN(SMIN), .STEP_DEF(SDEF),
    .STEP_DELTA(SD), .DEAD_CYC(DC), .PWM_W(PW)
  ) dut (
    .clk(clk), .nRst(nRst), .m3start(m3start), .m3forceStop(m3forceStop),
    .m3invRotate(m3invRotate), .m3freqINC(m3freqINC), .m3freqDEC(m3freqDEC),
    .duty(duty), .hp(hp), .lp(lp), .busy(busy), .stepIdx(stepIdx),
    .stepPeriod(stepPeriod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_UP, M_RUN, M_DOWN, M_BRAKE} mode_t;
  mode_t m_mode;
  int m_k, m_rem, m_cur, m_tgt, m_car, m_dut, e_hp, e_lp;
  bit m_dir;
  int m_last[P];
  int m_since[P];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 0 = off, 1 = high, 2 = low
  function automatic int lvl_of(int p);
    if (m_mode == M_IDLE) return 0;
    if (m_mode == M_BRAKE) return 2;
    return ((((m_k - 2 * p) % K2) + K2) % K2) < P ? 1 : 2;
  endfunction

  function automatic int toward(int c, int g);
    if (c > g) return (c - g <= SD) ? g : c - SD;
    if (c < g) return (g - c <= SD) ? g : c + SD;
    return c;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_k = 0; m_rem = 0; m_cur = SS; m_tgt = SDEF; m_dir = 0;
    m_car = 0; m_dut = 0; e_hp = 0; e_lp = 0;
    for (int p = 0; p < P; p++) begin m_last[p] = 0; m_since[p] = DC; end
  endtask

  task automatic model_step();
    int ot;
    bit com;
    if (!nRst) begin model_reset(); return; end
    e_hp = 0; e_lp = 0;
    for (int p = 0; p < P; p++) begin
      int l;
      l = lvl_of(p);
      if (l != m_last[p]) begin m_last[p] = l; m_since[p] = 0; end
      else if (m_since[p] < DC) m_since[p]++;
      if (m_since[p] >= DC) begin
        if (l == 1 && m_car < m_dut) e_hp |= (1 << p);
        if (l == 2) e_lp |= (1 << p);
      end
    end
    if (m_car == CMAX) m_dut = int'(duty);
    m_car = (m_car + 1) % (CMAX + 1);
    ot = m_tgt;
    if (m3freqINC && !m3freqDEC) m_tgt = (ot - SD < SMIN) ? SMIN : ot - SD;
    else if (m3freqDEC && !m3freqINC) m_tgt = (ot + SD > SS) ? SS : ot + SD;
    if (m3forceStop) m_mode = M_BRAKE;
    else if (m_mode == M_IDLE) begin
      if (m3start) begin
        m_mode = M_UP; m_k = 0; m_rem = SS; m_cur = SS; m_dir = m3invRotate;
      end
    end else if (m_mode == M_BRAKE) m_mode = M_IDLE;
    else begin
      com = (m_rem == 1);
      if (com) begin
        m_cur = toward(m_cur, (m_mode == M_DOWN) ? SS : ot);
        m_k   = m_dir ? (m_k + K2 - 1) % K2 : (m_k + 1) % K2;
        m_rem = m_cur;
      end else m_rem--;
      case (m_mode)
        M_UP:    if (!m3start) m_mode = M_DOWN; else if (com && m_cur == ot) m_mode = M_RUN;
        M_RUN:   if (!m3start) m_mode = M_DOWN;
        M_DOWN:  if (m3start) m_mode = M_UP; else if (com && m_cur == SS) m_mode = M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("hp", hp, e_hp);
    chk("lp", lp, e_lp);
    chk("busy", busy, (m_mode != M_IDLE));
    chk("stepIdx", stepIdx, m_k);
    chk("stepPeriod", stepPeriod, m_cur);
    chk("overlap", hp & lp, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_step(output int n);
    logic [2:0] old;
    old = stepIdx;
    n = 0;
    do begin tick(); n++; end while (stepIdx == old && n < 200);
    chk("step_seen", (stepIdx != old), 1);
  endtask

  task automatic wait_period(input int v, input int bound);
    int n;
    n = 0;
    while (stepPeriod != v && n < bound) begin tick(); n++; end
    chk("period_reach", stepPeriod, v);
  endtask

  initial begin
    int n, hcnt;
    int lens[6];
    lens = '{20, 16, 12, 8, 8, 8};
    nRst = 0; m3start = 0; m3forceStop = 0; m3invRotate = 0;
    m3freqINC = 0; m3freqDEC = 0; duty = 4'd15;
    ticks(2);
    chk("rst_hp", hp, 0); chk("rst_lp", lp, 0); chk("rst_busy", busy, 0);
    chk("rst_idx", stepIdx, 0); chk("rst_period", stepPeriod, SS);
    nRst = 1;
    ticks(3);

    // ramp-up: forward, step lengths and k sequence
    m3start = 1;
    tick();
    chk("busy_rise", busy, 1);
    tick(); chk("blank0", hp | lp, 0);
    tick(); chk("blank1", hp | lp, 0);
    tick(); chk("lp_k0", lp, 3'b010);
    for (int i = 0; i < 6; i++) begin
      wait_step(n);
      chk("step_len", (i == 0) ? n + 3 : n, lens[i]);
      chk("k_fwd", stepIdx, (i + 1) % K2);
    end

    // stop from RUN: period ramps back to STEP_START, then idle
    m3start = 0;
    wait_step(n); chk("down12", stepPeriod, 12);
    wait_step(n); chk("down16", stepPeriod, 16);
    wait_step(n); chk("down20", stepPeriod, 20);
    chk("stop_idle", busy, 0);
    tick(); chk("stop_hp", hp, 0); chk("stop_lp", lp, 0);

    // direction toggle while busy is ignored; then brake
    m3start = 1;
    tick(); ticks(2);
    m3invRotate = 1;
    wait_step(n); chk("dir_ignored", stepIdx, 1);
    ticks(5); chk("lp_k1", lp, 3'b110);
    m3forceStop = 1;
    tick();
    tick(); chk("brake_hp", hp, 0); chk("brake_lp1", lp, 3'b110);
    tick(); chk("brake_lp2", lp, 3'b110);
    tick(); chk("brake_lp3", lp, 3'b111);
    m3forceStop = 0; m3start = 0; m3invRotate = 0;
    tick(); chk("brake_exit", busy, 0);
    ticks(3);

    // reverse direction and target clamping
    m3invRotate = 1; m3start = 1;
    tick();
    wait_step(n); chk("k_rev5", stepIdx, 5);
    wait_step(n); chk("k_rev4", stepIdx, 4);
    for (int i = 0; i < 10; i++) begin
      m3freqINC = 1; tick(); m3freqINC = 0; tick();
    end
    wait_period(SMIN, 400);
    m3freqDEC = 1; tick(); m3freqDEC = 0;
    wait_period(8, 400);
    m3freqINC = 1; m3freqDEC = 1; tick(); m3freqINC = 0; m3freqDEC = 0;
    ticks(40); chk("incdec_hold", stepPeriod, 8);

    // PWM: duty 0 gives no high side; duty changes apply after wrap
    duty = 4'd0; ticks(17);
    hcnt = 0;
    for (int i = 0; i < 48; i++) begin tick(); if (hp != 0) hcnt++; end
    chk("duty0_hp", hcnt, 0);
    duty = 4'd4; ticks(64);
    ticks(5); duty = 4'd9; ticks(40);

    // reset mid-run
    nRst = 0; tick();
    chk("mrst_hp", hp, 0); chk("mrst_lp", lp, 0); chk("mrst_busy", busy, 0);
    chk("mrst_idx", stepIdx, 0); chk("mrst_period", stepPeriod, SS);
    nRst = 1; m3start = 0; ticks(2);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) m3start = ~m3start;
      m3forceStop = m3forceStop ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 299) == 0);
      m3freqINC   = ($urandom_range(0, 15) == 0);
      m3freqDEC   = ($urandom_range(0, 15) == 0);
      m3invRotate = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) duty = 4'($urandom_range(0, 15));
      nRst = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
